hvac_sequencer: RTL and testbench

- Sits between smart_thermostat and the HVAC actuator drivers.
- Turns the thermostat's raw heating/cooling requests into safe actuator commands:
  - fan pre-purge and post-purge,
  - minimum run time,
  - lockout (rest) time after each run,
  - heat/cool mutual exclusion.
- All timing counts a slow tick strobe (e.g. 1 Hz) supplied by the system timebase.

---
 rtl/hvac_sequencer.sv | 136 +++++++++++++
 tb/tb_hvac_sequencer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/hvac_sequencer.sv
// rtl/hvac_sequencer.sv - HVAC actuator sequencer: purge, minimum run, lockout, heat/cool exclusion
// Optional run limit enabled by defining MAX_RUN_EN.
module hvac_sequencer #(
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned PRE_TICKS     = 2,
  parameter int unsigned MIN_RUN_TICKS = 5,
  parameter int unsigned POST_TICKS    = 3,
  parameter int unsigned LOCKOUT_TICKS = 4,
  parameter int unsigned MAX_RUN_TICKS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       enable,
  input  logic       heat_req,
  input  logic       cool_req,
  output logic       fan_on,
  output logic       heater_on,
  output logic       compressor_on,
  output logic [2:0] state,
  output logic       conflict,
  output logic       max_run_hit
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FAN_PRE  = 3'd1,
    S_HEAT     = 3'd2,
    S_COOL     = 3'd3,
    S_FAN_POST = 3'd4,
    S_LOCKOUT  = 3'd5
  } state_t;

  localparam logic MODE_HEAT = 1'b0;
  localparam logic MODE_COOL = 1'b1;

  state_t           cur, nxt;
  logic [CNT_W-1:0] cnt;
  logic             mode, mode_nxt;
  logic             fan_d, heater_d, compressor_d;
  logic             dropped, min_done;

  // A timed state of length n ends on its nth tick, or immediately when n is zero.
  function automatic logic done_at(input int unsigned n);
    if (n == 0) return 1'b1;
    return tick && (cnt == CNT_W'(n - 1));
  endfunction

  // The running state's own request counts as dropped if it falls, the opposite one rises, or enable falls.
  always_comb begin
    dropped = !enable;
    if (cur == S_HEAT) dropped = dropped || !heat_req || cool_req;
    if (cur == S_COOL) dropped = dropped || !cool_req || heat_req;
    min_done = (cnt >= CNT_W'(MIN_RUN_TICKS)) || done_at(MIN_RUN_TICKS);
  end

`ifdef MAX_RUN_EN
  logic hit_nxt;
  logic hit_q;
`endif

  // Next-state and next-output decode; outputs are taken from the next state so they move with it.
  always_comb begin
    nxt      = cur;
    mode_nxt = mode;
`ifdef MAX_RUN_EN
    hit_nxt  = 1'b0;
`endif
    case (cur)
      S_IDLE: begin
        if (enable && heat_req && !cool_req) begin
          nxt      = S_FAN_PRE;
          mode_nxt = MODE_HEAT;
        end else if (enable && cool_req && !heat_req) begin
          nxt      = S_FAN_PRE;
          mode_nxt = MODE_COOL;
        end
      end
      S_FAN_PRE: begin
        if (!enable || (mode == MODE_HEAT ? !heat_req : !cool_req)) nxt = S_IDLE;
        else if (done_at(PRE_TICKS)) nxt = (mode == MODE_HEAT) ? S_HEAT : S_COOL;
      end
      S_HEAT, S_COOL: begin
`ifdef MAX_RUN_EN
        if (done_at(MAX_RUN_TICKS)) begin
          nxt     = S_FAN_POST;
          hit_nxt = 1'b1;
        end else
`endif
        if (dropped && min_done) nxt = S_FAN_POST;
      end
      S_FAN_POST: if (done_at(POST_TICKS)) nxt = S_LOCKOUT;
      S_LOCKOUT:  if (done_at(LOCKOUT_TICKS)) nxt = S_IDLE;
      default:    nxt = S_IDLE;
    endcase

    fan_d        = (nxt == S_FAN_PRE) || (nxt == S_HEAT) || (nxt == S_COOL) || (nxt == S_FAN_POST);
    heater_d     = (nxt == S_HEAT);
    compressor_d = (nxt == S_COOL);
  end

  // State, counter, mode and registered actuator commands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur           <= S_IDLE;
      cnt           <= '0;
      mode          <= MODE_HEAT;
      fan_on        <= 1'b0;
      heater_on     <= 1'b0;
      compressor_on <= 1'b0;
    end else begin
      cur           <= nxt;
      mode          <= mode_nxt;
      fan_on        <= fan_d;
      heater_on     <= heater_d;
      compressor_on <= compressor_d;
      if (nxt != cur)             cnt <= '0;
      else if (tick && cnt != '1) cnt <= cnt + 1'b1;
    end
  end

`ifdef MAX_RUN_EN
  // One-cycle pulse accompanying a forced stop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) hit_q <= 1'b0;
    else       hit_q <= hit_nxt;
  end
  assign max_run_hit = hit_q;
`else
  assign max_run_hit = 1'b0;
`endif

  assign state    = cur;
  assign conflict = (cur == S_IDLE) && heat_req && cool_req;

endmodule

// File: tb/tb_hvac_sequencer.sv
// tb/tb_hvac_sequencer.sv - randomized self-checking bench for hvac_sequencer
module tb_hvac_sequencer;

  localparam int PRE = 2, MIN = 5, POST = 3, LOCK = 4, MAXR = 10;

  logic       clk = 1'b0;
  logic       reset, tick, enable, heat_req, cool_req;
  logic       fan_on, heater_on, compressor_on, conflict, max_run_hit;
  logic [2:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: phase number, ticks seen in the phase, heat/cool mode, pending pulse.
  int m_phase, m_ticks;
  bit m_cool, m_hit;

  hvac_sequencer dut (
    .clk(clk), .reset(reset), .tick(tick), .enable(enable),
    .heat_req(heat_req), .cool_req(cool_req),
    .fan_on(fan_on), .heater_on(heater_on), .compressor_on(compressor_on),
    .state(state), .conflict(conflict), .max_run_hit(max_run_hit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input string where);
    check({where, ".state"}, int'(state), m_phase);
    check({where, ".fan"}, int'(fan_on), int'(m_phase inside {1, 2, 3, 4}));
    check({where, ".heater"}, int'(heater_on), int'(m_phase == 2));
    check({where, ".compressor"}, int'(compressor_on), int'(m_phase == 3));
    check({where, ".max_run_hit"}, int'(max_run_hit), int'(m_hit));
  endtask

  // A phase lasting n ticks is over once the ticks seen, counting this edge, reach n.
  function automatic bit over(int n);
    return (m_ticks + int'(tick)) >= n;
  endfunction

  task automatic model_step();
    int  nxt;
    bit  own, dropped;
    nxt   = m_phase;
    m_hit = 0;
    own   = m_cool ? cool_req : heat_req;
    case (m_phase)
      0: if (enable && heat_req != cool_req) begin
           nxt    = 1;
           m_cool = cool_req;
         end
      1: if (!enable || !own) nxt = 0;
         else if (over(PRE)) nxt = m_cool ? 3 : 2;
      2, 3: begin
        dropped = !enable || !own || (m_cool ? heat_req : cool_req);
`ifdef MAX_RUN_EN
        if (tick && m_ticks == MAXR - 1) begin
          nxt   = 4;
          m_hit = 1;
        end else
`endif
        if (dropped && over(MIN)) nxt = 4;
      end
      4: if (over(POST)) nxt = 5;
      5: if (over(LOCK)) nxt = 0;
      default: nxt = 0;
    endcase
    if (nxt != m_phase) m_ticks = 0;
    else                m_ticks += int'(tick);
    m_phase = nxt;
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; enable = 1'b0; heat_req = 1'b0; cool_req = 1'b0;
    m_phase = 0; m_ticks = 0; m_cool = 0; m_hit = 0;
    @(negedge clk);
    @(negedge clk);
    check_outputs("reset");
    check("reset.conflict", int'(conflict), 0);
    reset = 1'b0;
    enable = 1'b1;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk);
        check_outputs("run");
      end

      if ($urandom_range(0, 149) == 0) begin
        #1 reset = 1'b1;
        #1;
        m_phase = 0; m_ticks = 0; m_hit = 0;
        check_outputs("async_reset");
        reset = 1'b0;
      end

      tick = (cyc < 2000) ? 1'b1 : 1'($urandom_range(0, 1));
      if ($urandom_range(0, 11) == 0) heat_req = ~heat_req;
      if ($urandom_range(0, 13) == 0) cool_req = ~cool_req;
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
      #1;
      check("conflict", int'(conflict), int'(m_phase == 0 && heat_req && cool_req));
      check("exclusive", int'(heater_on && compressor_on), 0);
      model_step();
    end

    @(negedge clk);
    check_outputs("final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
